alu_exec_unit: RTL

Parametrised execute-stage ALU for the multi-cycle RV32 core. It subsumes the combinational ALU-control decode and adds a full RV32I ALU, a branch-condition output and an iterative RV32M multiply/divide datapath. It sits between the register-read stage and writeback, and uses valid/ready handshakes on both sides. Single-cycle ops complete in 1 cycle; MUL/DIV ops hold the unit busy for XLEN cycles.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_exec_unit_mdu_iter.sv | 120 ++++++++++++
 rtl/alu_exec_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [6:0] OPC_ARITH     = 7'b0110011;
  localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd,
    AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu,
    AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu,
    AluPassB
  } alu_op_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  function automatic logic is_mul_op(alu_op_e op);
    return op inside {AluMul, AluMulh, AluMulhsu, AluMulhu};
  endfunction

  function automatic logic is_div_op(alu_op_e op);
    return op inside {AluDiv, AluDivu, AluRem, AluRemu};
  endfunction

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide: one shift-add or shift-subtract step per cycle on
// operand magnitudes, sign fixup applied to the final step's output.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            sel_hi_q, sel_hi_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d;

  logic            a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ok;
  logic [XLEN-1:0] step_hi, step_lo, div_val;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    a_signed = op inside {AluMulh, AluMulhsu, AluDiv, AluRem};
    b_signed = op inside {AluMulh, AluDiv, AluRem};
    neg_a    = a_signed & a[XLEN-1];
    neg_b    = b_signed & b[XLEN-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
  end

  // hi/lo hold {accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    div_ok    = ~div_diff[XLEN];
    if (is_div_q) begin
      step_hi = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ok};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? -prod : prod;
    div_val  = sel_hi_q ? step_hi : step_lo;
    if (is_div_q) begin
      result = neg_q ? -div_val : div_val;
    end else begin
      result = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
    done = busy_q && (cnt_q == '0);
  end

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mag_d    = mag_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CntW'(XLEN - 1);
      is_div_d = is_div_op(op);
      sel_hi_d = op inside {AluMulh, AluMulhsu, AluMulhu, AluRem, AluRemu};
      neg_d    = op inside {AluRem, AluRemu} ? neg_a : (neg_a ^ neg_b);
      hi_d     = '0;
      lo_d     = is_div_op(op) ? mag_a : mag_b;
      mag_d    = is_div_op(op) ? mag_b : mag_a;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_q    <= mag_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALU-control decode, single-cycle RV32I ALU, branch compare, and the
// handshake FSM around the iterative multiply/divide unit.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [1:0]      alu_ctrl_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            bcond,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned ShW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            bcond_q, bcond_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  alu_op_e         dec_op;
  logic            dec_illegal;
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] diff, alu_res, spec_res, mdu_result;
  logic            lt_s, lt_u, eq, alu_bcond;
  logic            is_mul, is_div, div_zero, div_ovf, div_special;
  logic            mdu_start, mdu_done;
  logic            unused_inst_bits;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  always_comb begin
    dec_op      = AluAdd;
    dec_illegal = 1'b0;
    unique case (alu_ctrl_op)
      2'b00: dec_op = AluAdd;
      2'b01: begin
        case (funct3)
          3'b000:  dec_op = AluBeq;
          3'b001:  dec_op = AluBne;
          3'b100:  dec_op = AluBlt;
          3'b101:  dec_op = AluBge;
          3'b110:  dec_op = AluBltu;
          3'b111:  dec_op = AluBgeu;
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (opcode == OPC_ARITH && funct7 == FUNCT7_MULDIV) begin
          if (MDU_EN) begin
            dec_op = alu_op_e'(5'(AluMul) + 5'(funct3));
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (opcode == OPC_ARITH && funct7 == FUNCT7_ALT) begin
          case (funct3)
            3'b000:  dec_op = AluSub;
            3'b101:  dec_op = AluSra;
            default: dec_illegal = 1'b1;
          endcase
        end else if ((opcode == OPC_ARITH && funct7 == FUNCT7_BASE) || opcode == OPC_ARITH_IMM) begin
          case (funct3)
            3'b000:  dec_op = AluAdd;
            3'b001:  dec_op = AluSll;
            3'b010:  dec_op = AluSlt;
            3'b011:  dec_op = AluSltu;
            3'b100:  dec_op = AluXor;
            // Only the immediate form reaches here with inst[30] possibly set.
            3'b101:  dec_op = inst[30] ? AluSra : AluSrl;
            3'b110:  dec_op = AluOr;
            default: dec_op = AluAnd;
          endcase
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: dec_op = AluPassB;
    endcase
  end

  always_comb begin
    shamt     = op_b[ShW-1:0];
    diff      = op_a - op_b;
    lt_s      = $signed(op_a) < $signed(op_b);
    lt_u      = op_a < op_b;
    eq        = op_a == op_b;
    alu_res   = '0;
    alu_bcond = 1'b0;
    case (dec_op)
      AluAdd:   alu_res = op_a + op_b;
      AluSub:   alu_res = diff;
      AluSll:   alu_res = op_a << shamt;
      AluSlt:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
      AluSltu:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      AluXor:   alu_res = op_a ^ op_b;
      AluSrl:   alu_res = op_a >> shamt;
      AluSra:   alu_res = $signed(op_a) >>> shamt;
      AluOr:    alu_res = op_a | op_b;
      AluAnd:   alu_res = op_a & op_b;
      AluPassB: alu_res = op_b;
      AluBeq:   begin alu_res = diff; alu_bcond = eq;    end
      AluBne:   begin alu_res = diff; alu_bcond = !eq;   end
      AluBlt:   begin alu_res = diff; alu_bcond = lt_s;  end
      AluBge:   begin alu_res = diff; alu_bcond = !lt_s; end
      AluBltu:  begin alu_res = diff; alu_bcond = lt_u;  end
      AluBgeu:  begin alu_res = diff; alu_bcond = !lt_u; end
      default:  alu_res = '0;
    endcase
    if (dec_illegal) begin
      alu_res   = '0;
      alu_bcond = 1'b0;
    end
  end

  // Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
  always_comb begin
    is_mul      = !dec_illegal && is_mul_op(dec_op);
    is_div      = !dec_illegal && is_div_op(dec_op);
    div_zero    = op_b == '0;
    div_ovf     = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1) &&
                  (dec_op inside {AluDiv, AluRem});
    div_special = is_div && (div_zero || div_ovf);
    if (dec_op inside {AluDiv, AluDivu}) begin
      spec_res = div_zero ? '1 : op_a;
    end else begin
      spec_res = div_zero ? op_a : '0;
    end
  end

  mdu_iter #(
    .XLEN(XLEN)
  ) u_mdu_iter (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (mdu_start),
    .op     (dec_op),
    .a      (op_a),
    .b      (op_b),
    .done   (mdu_done),
    .result (mdu_result)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    bcond_d   = bcond_q;
    illegal_d = illegal_q;
    mdu_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if ((is_mul || is_div) && !div_special) begin
            mdu_start = 1'b1;
            state_d   = is_mul ? StMul : StDiv;
            bcond_d   = 1'b0;
            illegal_d = 1'b0;
          end else begin
            state_d   = StDone;
            result_d  = div_special ? spec_res : alu_res;
            bcond_d   = alu_bcond;
            illegal_d = dec_illegal;
          end
        end
      end
      StMul, StDiv: begin
        if (mdu_done) begin
          state_d  = StDone;
          result_d = mdu_result;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      bcond_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      bcond_q   <= bcond_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = reset_n && (state_q == StIdle);
  assign out_valid = state_q == StDone;
  assign busy      = state_q inside {StMul, StDiv};
  assign result    = result_q;
  assign bcond     = bcond_q;
  assign illegal   = illegal_q;

endmodule
